tmr_fault_injector: RTL
=======================

TMR_FAULT_INJECTOR -- requirements
Module: tmr_fault_injector

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of each triplicated lane.
REQ-002 SHALL have parameter PERIOD_W, default 16, giving the width of the inter-injection period.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in  input  WIDTH  data to triplicate.
REQ-006 outA, outB, outC  output  WIDTH  triplicated lanes, driven to a majority voter.
REQ-007 arm  input  1  campaign start strobe.
REQ-008 abort  input  1  campaign cancel strobe.
REQ-009 lane_sel  input  2  lane to corrupt: 0=A, 1=B, 2=C, 3=rotate A->B->C->A.
REQ-010 inj_mask  input  WIDTH  bits XORed into the selected lane during injection.
REQ-011 period  input  PERIOD_W  cycles between injections.
REQ-012 count  input  8  number of injections per campaign.
REQ-013 tmrErr_in  input  1  error flag returned by the voter.
REQ-014 busy  output  1  campaign in progress.
REQ-015 done  output  1  one-cycle pulse when a campaign completes.
REQ-016 inj_active  output  1  high while a corruption is on the lanes.
REQ-017 detected_cnt, missed_cnt  output  8  campaign detection statistics.

Function
REQ-018 SHALL register in into in_q each cycle; outX SHALL equal in_q, except that the injected lane SHALL equal in_q ^ inj_mask. Latency from in to out is 1 cycle.
REQ-019 SHALL implement FSM states IDLE, WAIT, INJECT and CHECK.
REQ-020 IDLE: when arm=1, SHALL latch lane_sel, inj_mask, period and count, then go to WAIT with the timer set to max(period,1). If the latched count is 0, it SHALL instead pulse done and remain in IDLE.
REQ-021 WAIT: SHALL decrement the timer each cycle; when the timer reaches 1, SHALL go to INJECT.
REQ-022 INJECT: SHALL last exactly 1 cycle with inj_active=1 and the selected lane corrupted, then go to CHECK.
REQ-023 CHECK: SHALL last 1 cycle with the lanes clean. An injection counts as detected if tmrErr_in=1 in the INJECT cycle or in the CHECK cycle; otherwise it counts as missed.
REQ-024 CHECK: after the last injection SHALL pulse done and go to IDLE; otherwise SHALL reload the timer and go to WAIT.
REQ-025 Rotate mode SHALL start on lane A for each campaign and advance one lane per injection.
REQ-026 An all-zero mask SHALL still run the full sequence; with a correct voter each such injection is counted as missed.
REQ-027 arm while busy SHALL be ignored; latched parameters SHALL NOT change mid-campaign.
REQ-028 abort SHALL return the FSM to IDLE on the next edge with the lanes clean; done SHALL NOT pulse, and the counters SHALL hold their values.
REQ-029 If abort and arm are both high in IDLE, abort SHALL win.
REQ-030 Counters SHALL be cleared on arm acceptance and SHALL saturate at 255.
REQ-031 busy SHALL be 1 in WAIT, INJECT and CHECK, and 0 in IDLE.

Reset
REQ-032 rst SHALL force IDLE, in_q=0, outA=outB=outC=0, busy=0, done=0, inj_active=0, detected_cnt=0, missed_cnt=0 and the timer to 0.
REQ-033 rst asserted mid-campaign SHALL remove any corruption on the following edge.

Configuration
REQ-034 With macro TMR_FAULT_INJ_STATS_EN defined, detected_cnt and missed_cnt SHALL operate as specified. Without it, both SHALL be constant 0 with no counter registers, and all other behaviour SHALL be unchanged.

Verification
REQ-035 WIDTH=8, in=0x5A, lane_sel=1, mask=0x01, period=4, count=2, real voter attached -> outB=0x5B for one cycle every 5 cycles; detected_cnt=2, missed_cnt=0; done pulses once.
REQ-036 lane_sel=3, count=4 -> corruption on lanes A, B, C, A in that order.
REQ-037 mask=0x00, count=3 -> lanes never differ; missed_cnt=3.
REQ-038 period=0, count=1 -> INJECT occurs 1 cycle after arm, done 2 cycles after INJECT.
REQ-039 abort asserted during the second WAIT of a count=5 campaign -> IDLE next cycle; no done; detected_cnt=1.
REQ-040 rst asserted in the INJECT cycle -> all outputs 0 next cycle; count=300 is not possible (8-bit), so tmrErr_in is forced to 1 for count=255 and detected_cnt is checked to saturate at 255.

Source files
------------

// File: rtl/tmr_fault_injector.sv
// Fault-injection campaign engine feeding three copies of a data word to a TMR voter.
// Optional statistics counters are built only when TMR_FAULT_INJ_STATS_EN is defined.
module tmr_fault_injector #(
    parameter int WIDTH    = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    in,
    output logic [WIDTH-1:0]    outA,
    output logic [WIDTH-1:0]    outB,
    output logic [WIDTH-1:0]    outC,
    input  logic                arm,
    input  logic                abort,
    input  logic [1:0]          lane_sel,
    input  logic [WIDTH-1:0]    inj_mask,
    input  logic [PERIOD_W-1:0] period,
    input  logic [7:0]          count,
    input  logic                tmrErr_in,
    output logic                busy,
    output logic                done,
    output logic                inj_active,
    output logic [7:0]          detected_cnt,
    output logic [7:0]          missed_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_INJECT, S_CHECK} state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    in_q;
    logic [WIDTH-1:0]    corr_a_q, corr_b_q, corr_c_q;
    logic                done_q, inj_q;
    logic [PERIOD_W-1:0] timer_q, period_q;
    logic [7:0]          remain_q;
    logic [1:0]          lane_q, rot_q;
    logic [WIDTH-1:0]    mask_q;

    logic [1:0]          cur_lane_s;
    logic [PERIOD_W-1:0] reload_s, arm_reload_s;
    logic [WIDTH-1:0]    inj_a_s, inj_b_s, inj_c_s;

    // Target lane and timer reload values (period 0 behaves as 1).
    always_comb begin
        cur_lane_s   = (lane_q == 2'd3) ? rot_q : lane_q;
        reload_s     = (period_q == '0) ? PERIOD_W'(1) : period_q;
        arm_reload_s = (period == '0) ? PERIOD_W'(1) : period;
        inj_a_s      = '0;
        inj_b_s      = '0;
        inj_c_s      = '0;
        case (cur_lane_s)
            2'd0:    inj_a_s = mask_q;
            2'd1:    inj_b_s = mask_q;
            2'd2:    inj_c_s = mask_q;
            default: inj_a_s = '0;
        endcase
    end

    // Campaign FSM with registered lane corruption and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            in_q     <= '0;
            corr_a_q <= '0;
            corr_b_q <= '0;
            corr_c_q <= '0;
            done_q   <= 1'b0;
            inj_q    <= 1'b0;
            timer_q  <= '0;
            period_q <= '0;
            remain_q <= 8'd0;
            lane_q   <= 2'd0;
            rot_q    <= 2'd0;
            mask_q   <= '0;
        end else begin
            in_q     <= in;
            corr_a_q <= '0;
            corr_b_q <= '0;
            corr_c_q <= '0;
            done_q   <= 1'b0;
            inj_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!abort && arm) begin
                        lane_q   <= lane_sel;
                        mask_q   <= inj_mask;
                        period_q <= period;
                        rot_q    <= 2'd0;
                        remain_q <= count;
                        if (count == 8'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                            timer_q <= arm_reload_s;
                        end
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - PERIOD_W'(1);
                        if (timer_q <= PERIOD_W'(2)) begin
                            state_q  <= S_INJECT;
                            inj_q    <= 1'b1;
                            corr_a_q <= inj_a_s;
                            corr_b_q <= inj_b_s;
                            corr_c_q <= inj_c_s;
                        end
                    end
                end
                S_INJECT: begin
                    state_q <= abort ? S_IDLE : S_CHECK;
                end
                S_CHECK: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        rot_q    <= (rot_q == 2'd2) ? 2'd0 : rot_q + 2'd1;
                        remain_q <= remain_q - 8'd1;
                        if (remain_q == 8'd1) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_WAIT;
                            timer_q <= reload_s;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign outA       = in_q ^ corr_a_q;
    assign outB       = in_q ^ corr_b_q;
    assign outC       = in_q ^ corr_c_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign inj_active = inj_q;

`ifdef TMR_FAULT_INJ_STATS_EN
    logic       err_seen_q;
    logic [7:0] det_q, det_d, miss_q, miss_d;

    // An injection is detected if the voter flagged it during INJECT or CHECK.
    always_comb begin
        det_d  = det_q;
        miss_d = miss_q;
        if (state_q == S_IDLE && arm && !abort) begin
            det_d  = 8'd0;
            miss_d = 8'd0;
        end else if (state_q == S_CHECK && !abort) begin
            if (err_seen_q || tmrErr_in) begin
                det_d = (det_q == 8'hFF) ? det_q : det_q + 8'd1;
            end else begin
                miss_d = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
            end
        end else begin
            det_d  = det_q;
            miss_d = miss_q;
        end
    end

    // Statistics registers and INJECT-cycle error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            det_q      <= 8'd0;
            miss_q     <= 8'd0;
            err_seen_q <= 1'b0;
        end else begin
            det_q  <= det_d;
            miss_q <= miss_d;
            if (state_q == S_INJECT) begin
                err_seen_q <= tmrErr_in;
            end else begin
                err_seen_q <= err_seen_q;
            end
        end
    end

    assign detected_cnt = det_q;
    assign missed_cnt   = miss_q;
`else
    logic unused_err_s;
    assign unused_err_s = tmrErr_in;
    assign detected_cnt = 8'd0;
    assign missed_cnt   = 8'd0;
`endif

endmodule
